// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: opcodes, ALUop encodings, control bundle and decoder.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    // Control bundle handed to ID/EX; all-zero is a bubble.
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Main control decode; unknown opcodes produce a bubble.
    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        c = CTRL_NOP;
        case (opcode)
            OP_R: begin
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_R;
            end
            OP_I: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALUOP_I;
            end
            OP_LD: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_src    = 1'b1;
                c.alu_op     = ALUOP_ADD;
            end
            OP_ST: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALUOP_ADD;
            end
            OP_BR: begin
                c.branch = 1'b1;
                c.alu_op = ALUOP_SUB;
            end
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: IF/ID inputs, hazard/writeback inputs and ID/EX-facing outputs.
// Latency: wires only.
// Backpressure: pc_write_o / if_id_write_o low asks the front end to hold.
interface id_stage_if #(parameter int XLEN = riscv_pkg::XLEN);

    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic            flush_i;
    logic            ex_MemRead_i;
    logic [4:0]      ex_wr_i;
    logic            wb_RegWrite_i;
    logic [4:0]      wb_wr_i;
    logic [XLEN-1:0] wb_data_i;

    logic            RegWrite_o;
    logic            MemToReg_o;
    logic            Branch_o;
    logic            MemRead_o;
    logic            MemWrite_o;
    logic            ALUsrc_o;
    logic [1:0]      ALUop_o;
    logic [XLEN-1:0] branchAddr_o;
    logic [XLEN-1:0] rd1_o;
    logic [XLEN-1:0] rd2_o;
    logic [XLEN-1:0] imm_o;
    logic [6:0]      funct7_o;
    logic [2:0]      funct3_o;
    logic [4:0]      wr_o;
    logic [4:0]      rs1_o;
    logic [4:0]      rs2_o;
    logic            pc_write_o;
    logic            if_id_write_o;
    logic [31:0]     stall_cnt_o;

    // Pipeline/testbench side.
    modport master (
        output instr_i, pc_i, flush_i, ex_MemRead_i, ex_wr_i,
               wb_RegWrite_i, wb_wr_i, wb_data_i,
        input  RegWrite_o, MemToReg_o, Branch_o, MemRead_o, MemWrite_o, ALUsrc_o,
               ALUop_o, branchAddr_o, rd1_o, rd2_o, imm_o, funct7_o, funct3_o,
               wr_o, rs1_o, rs2_o, pc_write_o, if_id_write_o, stall_cnt_o
    );

    // Decode-stage side.
    modport slave (
        input  instr_i, pc_i, flush_i, ex_MemRead_i, ex_wr_i,
               wb_RegWrite_i, wb_wr_i, wb_data_i,
        output RegWrite_o, MemToReg_o, Branch_o, MemRead_o, MemWrite_o, ALUsrc_o,
               ALUop_o, branchAddr_o, rd1_o, rd2_o, imm_o, funct7_o, funct3_o,
               wr_o, rs1_o, rs2_o, pc_write_o, if_id_write_o, stall_cnt_o
    );

endinterface

// File: rtl/id_stage_regfile.sv
// 2-read/1-write register file, x0 hardwired to zero; optional write-through via ID_WB_BYPASS_EN.
// Latency: reads combinational, writes visible the cycle after the write edge (same cycle with bypass).
// Backpressure: none; the write port is always accepted.
module regfile #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra1_i,
    input  logic [4:0]      ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] regs_q [NREG];

    // Write port: clear everything on reset, never store into x0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

`ifdef ID_WB_BYPASS_EN
    logic byp1;
    logic byp2;

    assign byp1 = we_i && (wa_i != 5'd0) && (wa_i == ra1_i);
    assign byp2 = we_i && (wa_i != 5'd0) && (wa_i == ra2_i);

    // Read ports with write-through so a value written this edge is seen in the same cycle.
    always_comb begin
        rd1_o = '0;
        rd2_o = '0;
        if (ra1_i != 5'd0) rd1_o = byp1 ? wd_i : regs_q[ra1_i];
        if (ra2_i != 5'd0) rd2_o = byp2 ? wd_i : regs_q[ra2_i];
    end
`else
    // Read ports return stored state; a same-cycle write is not visible yet.
    always_comb begin
        rd1_o = '0;
        rd2_o = '0;
        if (ra1_i != 5'd0) rd1_o = regs_q[ra1_i];
        if (ra2_i != 5'd0) rd2_o = regs_q[ra2_i];
    end
`endif

endmodule

// File: rtl/id_stage.sv
// RISC-V decode stage: control decode, immediates, branch target, regfile, load-use hazard, stall count.
// Latency: all outputs combinational except stall_cnt_o (registered); build option ID_WB_BYPASS_EN.
// Backpressure: load-use hazard drops pc_write_o/if_id_write_o for one cycle and emits a bubble.
module id_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int NREG = 32
) (
    input  logic      clk,
    input  logic      rst,
    id_stage_if.slave bus
);

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm;
    ctrl_t           dec_ctrl;
    ctrl_t           out_ctrl;
    logic            uses_rs2;
    logic            hazard;
    logic            stall;
    logic [31:0]     stall_cnt_q;
    logic [31:0]     stall_cnt_d;

    assign instr  = bus.instr_i;
    assign opcode = instr[6:0];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

    // Immediate selection by format; formats without an immediate give zero.
    always_comb begin
        imm = '0;
        case (opcode)
            OP_I, OP_LD: imm = imm_i;
            OP_ST:       imm = imm_s;
            OP_BR:       imm = imm_b;
            default:     imm = '0;
        endcase
    end

    // Only R, S and B formats actually read rs2; I-type bits [24:20] are immediate.
    assign uses_rs2 = (opcode == OP_R) || (opcode == OP_ST) || (opcode == OP_BR);
    assign hazard   = bus.ex_MemRead_i && (bus.ex_wr_i != 5'd0) &&
                      ((bus.ex_wr_i == rs1) || ((bus.ex_wr_i == rs2) && uses_rs2));
    // A flush squashes this instruction, so any stall it would have caused is moot.
    assign stall    = hazard && !bus.flush_i && !rst;

    assign dec_ctrl = decode_ctrl(opcode);

    // Bubble the controls on hazard, flush or reset.
    always_comb begin
        out_ctrl = dec_ctrl;
        if (hazard || bus.flush_i || rst) out_ctrl = CTRL_NOP;
    end

    regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (rs1),
        .ra2_i (rs2),
        .rd1_o (bus.rd1_o),
        .rd2_o (bus.rd2_o),
        .we_i  (bus.wb_RegWrite_i),
        .wa_i  (bus.wb_wr_i),
        .wd_i  (bus.wb_data_i)
    );

    // Stall counter next state; wraps naturally at 2^32.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.RegWrite_o    = out_ctrl.reg_write;
    assign bus.MemToReg_o    = out_ctrl.mem_to_reg;
    assign bus.Branch_o      = out_ctrl.branch;
    assign bus.MemRead_o     = out_ctrl.mem_read;
    assign bus.MemWrite_o    = out_ctrl.mem_write;
    assign bus.ALUsrc_o      = out_ctrl.alu_src;
    assign bus.ALUop_o       = out_ctrl.alu_op;
    assign bus.branchAddr_o  = bus.pc_i + imm_b;
    assign bus.imm_o         = imm;
    assign bus.funct7_o      = instr[31:25];
    assign bus.funct3_o      = instr[14:12];
    assign bus.wr_o          = instr[11:7];
    assign bus.rs1_o         = rs1;
    assign bus.rs2_o         = rs2;
    assign bus.pc_write_o    = !stall;
    assign bus.if_id_write_o = !stall;
    assign bus.stall_cnt_o   = stall_cnt_q;

endmodule
